// File: rtl/keccak_chi_iota_unit.sv
// Keccak chi step with optional fused iota.
// Evaluates ROWS_PER_CYCLE rows of the 5x5 lane state per clock. It uses a
// start/done handshake plus a combinational ready, which is high only in IDLE.
module keccak_chi_iota_unit #(
  parameter int LANE_W         = 64,
  parameter int ROWS_PER_CYCLE = 5,
  parameter int FUSE_IOTA      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [25*LANE_W-1:0]  state,
  input  logic [63:0]           rc,
  output logic                  ready,
  output logic                  done,
  output logic [25*LANE_W-1:0]  chi_transform
);

  localparam int S  = 25 * LANE_W;
  localparam int RW = 5 * LANE_W;
  localparam int L  = 5 / ROWS_PER_CYCLE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t              fsm_r;
  fsm_t              fsm_nxt_s;
  logic [2:0]        row_cnt_r;
  logic [S-1:0]      state_copy_r;
  logic [63:0]       rc_copy_r;
  logic [S-1:0]      chi_port_s;
  logic [RW-1:0]     chi_run_row_s;

  // Chi over one row: each lane mixes with its two right neighbours (mod 5).
  function automatic logic [RW-1:0] chi_row(input logic [RW-1:0] a);
    logic [RW-1:0] r;
    r = '0;
    for (int x = 0; x < 5; x++) begin
      r[x*LANE_W +: LANE_W] = a[x*LANE_W +: LANE_W] ^
                              (~a[((x+1)%5)*LANE_W +: LANE_W] &
                                a[((x+2)%5)*LANE_W +: LANE_W]);
    end
    return r;
  endfunction

  // Iota: fold the round constant into lane (0,0) when row 0 is produced.
  function automatic logic [RW-1:0] iota_row(input logic [RW-1:0] r,
                                             input logic [63:0]   rcv,
                                             input logic          is_row0);
    logic [RW-1:0] o;
    o = r;
    if (is_row0 && (FUSE_IOTA == 1)) begin
      o[LANE_W-1:0] = r[LANE_W-1:0] ^ rcv[LANE_W-1:0];
    end else begin
      o = r;
    end
    return o;
  endfunction

  assign ready = (fsm_r == IDLE);

  // Rows computed straight from the input ports (used on the accepting edge).
  always_comb begin
    chi_port_s = '0;
    for (int y = 0; y < 5; y++) begin
      chi_port_s[y*RW +: RW] = iota_row(chi_row(state[y*RW +: RW]), rc, (y == 0));
    end
  end

  // Row selected by row_cnt, computed from the latched state copy.
  always_comb begin
    chi_run_row_s = iota_row(chi_row(state_copy_r[int'(row_cnt_r)*RW +: RW]),
                             rc_copy_r, (row_cnt_r == 3'd0));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r <= IDLE;
    end else begin
      fsm_r <= fsm_nxt_s;
    end
  end

  // FSM next-state logic; new requests are only taken in IDLE.
  always_comb begin
    fsm_nxt_s = fsm_r;
    case (fsm_r)
      IDLE: begin
        if (start) begin
          fsm_nxt_s = (L == 1) ? DONE : RUN;
        end else begin
          fsm_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (row_cnt_r == 3'd4) begin
          fsm_nxt_s = DONE;
        end else begin
          fsm_nxt_s = RUN;
        end
      end
      DONE:    fsm_nxt_s = IDLE;
      default: fsm_nxt_s = IDLE;
    endcase
  end

  // Datapath: latch operands, write result rows, and generate the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done          <= 1'b0;
      chi_transform <= '0;
      state_copy_r  <= '0;
      rc_copy_r     <= 64'd0;
      row_cnt_r     <= 3'd0;
    end else begin
      done <= (fsm_nxt_s == DONE);
      case (fsm_r)
        IDLE: begin
          if (start) begin
            for (int y = 0; y < ROWS_PER_CYCLE; y++) begin
              chi_transform[y*RW +: RW] <= chi_port_s[y*RW +: RW];
            end
            state_copy_r <= state;
            rc_copy_r    <= rc;
            row_cnt_r    <= 3'd1;
          end
        end
        RUN: begin
          chi_transform[int'(row_cnt_r)*RW +: RW] <= chi_run_row_s;
          row_cnt_r <= row_cnt_r + 3'd1;
        end
        DONE:    row_cnt_r <= 3'd0;
        default: row_cnt_r <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_chi_iota_unit.sv
// Directed bench for keccak_chi_iota_unit across four parameterisations:
// A: 64-bit lanes, 5 rows per cycle, no iota
// B: 64-bit lanes, 1 row per cycle, no iota
// C: 64-bit lanes, 5 rows per cycle, iota
// D: 8-bit lanes, 1 row per cycle, iota
module tb_keccak_chi_iota_unit;

  localparam int S64 = 1600;
  localparam int S8  = 200;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, start_c, start_d;
  logic [S64-1:0] st64;
  logic [S8-1:0]  st8;
  logic [63:0]    rc;
  logic ready_a, ready_b, ready_c, ready_d;
  logic done_a, done_b, done_c, done_d;
  logic [S64-1:0] chi_a, chi_b, chi_c;
  logic [S8-1:0]  chi_d;

  int total = 0;
  int bad   = 0;
  int li;
  int lat;
  int pulses;
  logic d1, d2, r1;
  logic [S64-1:0] all1, vec_sb, exp_sb, vec_r2, exp_r2, exp64;
  logic [S8-1:0]  exp8;

  always #5 clk = ~clk;

  keccak_chi_iota_unit #(.LANE_W(64), .ROWS_PER_CYCLE(5), .FUSE_IOTA(0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .state(st64), .rc(rc),
    .ready(ready_a), .done(done_a), .chi_transform(chi_a));
  keccak_chi_iota_unit #(.LANE_W(64), .ROWS_PER_CYCLE(1), .FUSE_IOTA(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .state(st64), .rc(rc),
    .ready(ready_b), .done(done_b), .chi_transform(chi_b));
  keccak_chi_iota_unit #(.LANE_W(64), .ROWS_PER_CYCLE(5), .FUSE_IOTA(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .state(st64), .rc(rc),
    .ready(ready_c), .done(done_c), .chi_transform(chi_c));
  keccak_chi_iota_unit #(.LANE_W(8), .ROWS_PER_CYCLE(1), .FUSE_IOTA(1)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .state(st8), .rc(rc),
    .ready(ready_d), .done(done_d), .chi_transform(chi_d));

  function automatic int first_diff(input logic [S64-1:0] a, input logic [S64-1:0] b);
    for (int i = 0; i < 25; i++) begin
      if (a[i*64 +: 64] !== b[i*64 +: 64]) return i;
    end
    return 0;
  endfunction

  // Single-cycle units: accept, capture done/ready in DONE, then the cycle after.
  task automatic go_a(input logic [S64-1:0] v, input logic [63:0] rcv,
                      output logic dn, output logic rdy, output logic dn_after);
    @(negedge clk); st64 = v; rc = rcv; start_a = 1'b1;
    @(posedge clk); #1; dn = done_a; rdy = ready_a;
    @(negedge clk); start_a = 1'b0;
    @(posedge clk); #1; dn_after = done_a;
  endtask

  task automatic go_c(input logic [S64-1:0] v, input logic [63:0] rcv);
    @(negedge clk); st64 = v; rc = rcv; start_c = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); start_c = 1'b0;
    @(posedge clk); #1;
  endtask

  // Row-serial units: accept, count edges until done (bounded), return to IDLE.
  task automatic go_b(input logic [S64-1:0] v, output int n);
    @(negedge clk); st64 = v; start_b = 1'b1;
    @(posedge clk); #1; n = 0;
    @(negedge clk); start_b = 1'b0; st64 = '0;
    while (done_b !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
  endtask

  task automatic go_d(input logic [S8-1:0] v, input logic [63:0] rcv, output int n);
    @(negedge clk); st8 = v; rc = rcv; start_d = 1'b1;
    @(posedge clk); #1; n = 0;
    @(negedge clk); start_d = 1'b0; rc = 64'd0;
    while (done_d !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
    st64 = '0; st8 = '0; rc = 64'd0;
    repeat (3) @(posedge clk); #1;
    total++; if ({done_a, done_b, done_c, done_d} !== 4'b0000) begin bad++; $display("FAIL rst_done got=%b want=0000", {done_a, done_b, done_c, done_d}); end
    total++; if ((chi_a | chi_b | chi_c) !== '0 || chi_d !== '0) begin bad++; $display("FAIL rst_chi got nonzero want=0"); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if ({ready_a, ready_b, ready_c, ready_d} !== 4'b1111) begin bad++; $display("FAIL rst_ready got=%b want=1111", {ready_a, ready_b, ready_c, ready_d}); end
  endtask

  task automatic test_zero_r5();
    go_a('0, 64'h8082, d1, r1, d2);
    total++; if (d1 !== 1'b1) begin bad++; $display("FAIL zero_a_done got=%b want=1", d1); end
    total++; if (r1 !== 1'b0) begin bad++; $display("FAIL zero_a_ready_in_done got=%b want=0", r1); end
    total++; if (d2 !== 1'b0) begin bad++; $display("FAIL zero_a_done_after got=%b want=0", d2); end
    total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL zero_a_ready_after got=%b want=1", ready_a); end
    total++; if (chi_a !== '0) begin li = first_diff(chi_a, '0); bad++; $display("FAIL zero_a_chi lane=%0d got=%h want=0", li, chi_a[li*64 +: 64]); end
  endtask

  task automatic test_ones_r1();
    @(negedge clk); st64 = all1; start_b = 1'b1;
    @(posedge clk); #1;
    total++; if (ready_b !== 1'b0 || done_b !== 1'b0) begin bad++; $display("FAIL ones_b_e0 got ready=%b done=%b want ready=0 done=0", ready_b, done_b); end
    total++; if (chi_b[319:0] !== all1[319:0]) begin bad++; $display("FAIL ones_b_row0 got=%h want all ones", chi_b[63:0]); end
    total++; if (chi_b[639:320] !== '0) begin bad++; $display("FAIL ones_b_row1_held got=%h want=0", chi_b[383:320]); end
    @(negedge clk); start_b = 1'b0; st64 = '0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      total++; if (done_b !== (k == 4) || ready_b !== 1'b0) begin bad++; $display("FAIL ones_b_edge%0d got done=%b ready=%b want done=%b ready=0", k, done_b, ready_b, (k == 4)); end
    end
    total++; if (chi_b !== all1) begin li = first_diff(chi_b, all1); bad++; $display("FAIL ones_b_chi lane=%0d got=%h want all ones", li, chi_b[li*64 +: 64]); end
    @(posedge clk); #1;
    total++; if (done_b !== 1'b0 || ready_b !== 1'b1) begin bad++; $display("FAIL ones_b_after got done=%b ready=%b want done=0 ready=1", done_b, ready_b); end
    repeat (3) @(posedge clk); #1;
    total++; if (chi_b !== all1) begin bad++; $display("FAIL ones_b_hold got lane0=%h want all ones", chi_b[63:0]); end
  endtask

  task automatic test_single_bit();
    go_a(vec_sb, 64'd0, d1, r1, d2);
    total++; if (chi_a !== exp_sb) begin li = first_diff(chi_a, exp_sb); bad++; $display("FAIL sb_a lane=%0d got=%h want=%h", li, chi_a[li*64 +: 64], exp_sb[li*64 +: 64]); end
    go_b(vec_sb, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL sb_b_latency got=%0d want=4", lat); end
    total++; if (chi_b !== exp_sb) begin li = first_diff(chi_b, exp_sb); bad++; $display("FAIL sb_b lane=%0d got=%h want=%h", li, chi_b[li*64 +: 64], exp_sb[li*64 +: 64]); end
  endtask

  task automatic test_row2();
    go_a(vec_r2, 64'd0, d1, r1, d2);
    total++; if (chi_a !== exp_r2) begin li = first_diff(chi_a, exp_r2); bad++; $display("FAIL r2_a lane=%0d got=%h want=%h", li, chi_a[li*64 +: 64], exp_r2[li*64 +: 64]); end
    go_b(vec_r2, lat);
    total++; if (chi_b !== exp_r2) begin li = first_diff(chi_b, exp_r2); bad++; $display("FAIL r2_b lane=%0d got=%h want=%h", li, chi_b[li*64 +: 64], exp_r2[li*64 +: 64]); end
  endtask

  task automatic test_iota();
    go_c('0, 64'h0000_0000_0000_8082);
    exp64 = '0; exp64[63:0] = 64'h8082;
    total++; if (chi_c !== exp64) begin li = first_diff(chi_c, exp64); bad++; $display("FAIL iota_c_zero lane=%0d got=%h want=%h", li, chi_c[li*64 +: 64], exp64[li*64 +: 64]); end
    go_c(vec_sb, 64'h0000_0000_0000_8082);
    exp64 = exp_sb; exp64[63:0] = 64'h8082;
    total++; if (chi_c !== exp64) begin li = first_diff(chi_c, exp64); bad++; $display("FAIL iota_c_sb lane=%0d got=%h want=%h", li, chi_c[li*64 +: 64], exp64[li*64 +: 64]); end
    go_d('0, 64'h0000_0000_0000_8082, lat);
    exp8 = '0; exp8[7:0] = 8'h82;
    total++; if (lat !== 4) begin bad++; $display("FAIL iota_d_latency got=%0d want=4", lat); end
    total++; if (chi_d !== exp8) begin bad++; $display("FAIL iota_d got=%h want=%h", chi_d, exp8); end
  endtask

  task automatic test_ignore_start();
    pulses = 0;
    @(negedge clk); st64 = vec_sb; start_b = 1'b1;
    @(posedge clk); #1; if (done_b === 1'b1) pulses++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); st64 = all1; start_b = 1'b1;
      @(posedge clk); #1; if (done_b === 1'b1) pulses++;
    end
    @(negedge clk); start_b = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (done_b === 1'b1) pulses++; end
    total++; if (pulses !== 1) begin bad++; $display("FAIL ign_pulses got=%0d want=1", pulses); end
    total++; if (chi_b !== exp_sb) begin li = first_diff(chi_b, exp_sb); bad++; $display("FAIL ign_chi lane=%0d got=%h want=%h", li, chi_b[li*64 +: 64], exp_sb[li*64 +: 64]); end
    total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL ign_ready got=%b want=1", ready_b); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk); st64 = all1; start_b = 1'b1;
    @(posedge clk);
    @(negedge clk); start_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    total++; if (chi_b !== '0 || done_b !== 1'b0) begin bad++; $display("FAIL mid_rst_clear got lane0=%h done=%b want 0", chi_b[63:0], done_b); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", ready_b); end
    pulses = 0;
    repeat (8) begin @(posedge clk); #1; if (done_b === 1'b1) pulses++; end
    total++; if (pulses !== 0) begin bad++; $display("FAIL mid_rst_pulses got=%0d want=0", pulses); end
    total++; if (chi_b !== '0) begin bad++; $display("FAIL mid_rst_chi got lane0=%h want=0", chi_b[63:0]); end
    go_b(vec_sb, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL mid_rst_fresh_latency got=%0d want=4", lat); end
    total++; if (chi_b !== exp_sb) begin li = first_diff(chi_b, exp_sb); bad++; $display("FAIL mid_rst_fresh lane=%0d got=%h want=%h", li, chi_b[li*64 +: 64], exp_sb[li*64 +: 64]); end
  endtask

  initial begin
    all1 = '1;
    // lane(1,0)=1 -> lanes (1,0) and (4,0) are 1
    vec_sb = '0; vec_sb[1*64 +: 64] = 64'd1;
    exp_sb = '0; exp_sb[1*64 +: 64] = 64'd1; exp_sb[4*64 +: 64] = 64'd1;
    // row 2: A1=0x00FF, A2=0x0F0F -> out0=0x0F00, out1=0xFF, out2=0x0F0F, out4=0xFF
    vec_r2 = '0; vec_r2[11*64 +: 64] = 64'h00FF; vec_r2[12*64 +: 64] = 64'h0F0F;
    exp_r2 = '0; exp_r2[10*64 +: 64] = 64'h0F00; exp_r2[11*64 +: 64] = 64'h00FF;
    exp_r2[12*64 +: 64] = 64'h0F0F; exp_r2[14*64 +: 64] = 64'h00FF;

    test_reset();
    test_zero_r5();
    test_ones_r1();
    test_single_bit();
    test_row2();
    test_iota();
    test_ignore_start();
    test_reset_mid_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
